// File: rtl/stream_dword_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_dword_serializer
//  Brief    : Buffers 32-bit words carrying 1-4 valid bytes in a small FIFO
//             and emits them one byte per cycle on a valid/ready stream.
//             Keeps an output byte counter and an illegal-length drop counter.
//  Revision : 1.0  initial release
// ============================================================================
module stream_dword_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stream_in_valid,
    output logic        stream_in_ready,
    input  logic [31:0] stream_in_data,
    input  logic [2:0]  stream_in_len,
    input  logic        stream_in_last,
    output logic        stream_out_valid,
    input  logic        stream_out_ready,
    output logic [7:0]  stream_out_data,
    output logic        stream_out_last,
    output logic [15:0] byte_count,
    output logic [7:0]  drop_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // FIFO entry layout: {data[31:0], len[2:0], last}
    logic [35:0]          mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;
    logic [c_CNT_W-1:0]   count_d;
    logic                 in_ready_q;
    logic                 in_ready_d;

    state_t               state_q;
    logic [31:0]          shift_q;
    logic [2:0]           len_q;
    logic                 last_q;
    logic [1:0]           idx_q;
    logic [15:0]          byte_cnt_q;
    logic [7:0]           drop_cnt_q;

    logic                 w_in_hs;
    logic                 w_len_ok;
    logic                 w_push;
    logic                 w_out_hs;
    logic                 w_at_last;
    logic                 w_fifo_ne;
    logic                 w_pop;
    logic [35:0]          w_head;

    assign w_in_hs   = stream_in_valid && in_ready_q;
    assign w_len_ok  = (stream_in_len != 3'd0) && (stream_in_len <= 3'd4);
    assign w_push    = w_in_hs && w_len_ok;
    assign w_out_hs  = (state_q == S_SHIFT) && stream_out_ready;
    assign w_at_last = ({1'b0, idx_q} == (len_q - 3'd1));
    assign w_fifo_ne = (count_q != '0);
    // Head is taken either to start from idle or to chain into the next word
    // on the final byte's handshake, so there is no bubble between words.
    assign w_pop     = w_fifo_ne && ((state_q == S_IDLE) || (w_out_hs && w_at_last));
    assign w_head    = mem_q[rd_ptr_q];

    // Next occupancy and ready; a pop while full keeps ready low for one cycle.
    always_comb begin
        count_d    = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        in_ready_d = (count_d < c_FULL) && (count_q != c_FULL);
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {stream_in_data, stream_in_len, stream_in_last};
        end
    end

    // FIFO pointers, occupancy and registered input ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Serializer FSM with the held word in a shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_fifo_ne) begin
                        shift_q <= w_head[35:4];
                        len_q   <= w_head[3:1];
                        last_q  <= w_head[0];
                        idx_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_out_hs) begin
                        if (!w_at_last) begin
                            idx_q   <= idx_q + 2'd1;
                            shift_q <= BIG_ENDIAN ? (shift_q << 8) : (shift_q >> 8);
                        end else if (w_fifo_ne) begin
                            shift_q <= w_head[35:4];
                            len_q   <= w_head[3:1];
                            last_q  <= w_head[0];
                            idx_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Observation counters: bytes wrap, drops saturate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (w_out_hs) byte_cnt_q <= byte_cnt_q + 16'd1;
            if (w_in_hs && !w_len_ok && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    generate
        if (BIG_ENDIAN) begin : g_big
            assign stream_out_data = shift_q[31:24];
        end else begin : g_little
            assign stream_out_data = shift_q[7:0];
        end
    endgenerate

    assign stream_in_ready  = in_ready_q;
    assign stream_out_valid = (state_q == S_SHIFT);
    assign stream_out_last  = last_q && w_at_last;
    assign byte_count       = byte_cnt_q;
    assign drop_count       = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_dword_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_dword_serializer
//  Brief    : Directed bench for stream_dword_serializer; a little-endian and a
//             big-endian instance share the stimulus and a byte scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_dword_serializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_len = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_le, in_ready_be;
    logic        out_valid_le, out_valid_be;
    logic [7:0]  out_data_le, out_data_be;
    logic        out_last_le, out_last_be;
    logic [15:0] bc_le, bc_be;
    logic [7:0]  dc_le, dc_be;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {be_last, be_data, le_last, le_data}
    logic [17:0] exp_q[$];
    logic        rand_rdy = 1'b0;
    logic        last_in_hs = 1'b0;
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;
    logic [17:0] prev_d = '0;

    always #5 clk = ~clk;

    stream_dword_serializer #(.FIFO_DEPTH(4), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .stream_in_valid(in_valid), .stream_in_ready(in_ready_le),
        .stream_in_data(in_data), .stream_in_len(in_len), .stream_in_last(in_last),
        .stream_out_valid(out_valid_le), .stream_out_ready(out_ready),
        .stream_out_data(out_data_le), .stream_out_last(out_last_le),
        .byte_count(bc_le), .drop_count(dc_le)
    );

    stream_dword_serializer #(.FIFO_DEPTH(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset_n(reset_n),
        .stream_in_valid(in_valid), .stream_in_ready(in_ready_be),
        .stream_in_data(in_data), .stream_in_len(in_len), .stream_in_last(in_last),
        .stream_out_valid(out_valid_be), .stream_out_ready(out_ready),
        .stream_out_data(out_data_be), .stream_out_last(out_last_be),
        .byte_count(bc_be), .drop_count(dc_be)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected bytes of one accepted legal word, for both byte orders.
    task automatic model_push(input logic [31:0] d, input logic [2:0] l, input logic la);
        int n;
        logic [31:0] w;
        logic        lb;
        n = int'(l);
        w = d;
        if (n >= 1 && n <= 4) begin
            for (int i = 0; i < n; i++) begin
                lb = la && (i == n - 1);
                exp_q.push_back({lb, w[(24 - 8 * i) +: 8], lb, w[(8 * i) +: 8]});
            end
        end
    endtask

    // One clock cycle: scoreboard the handshakes that the coming edge performs.
    task automatic tick();
        logic [17:0] cur;
        logic [17:0] e;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        last_in_hs = 1'b0;
        if (reset_n) begin
            cur = {out_last_be, out_data_be, out_last_le, out_data_le};
            check("be_valid_match", 64'(out_valid_be), 64'(out_valid_le));
            check("be_ready_match", 64'(in_ready_be), 64'(in_ready_le));
            if (prev_v && !prev_hs) begin
                check("hold_stable", 64'({out_valid_le, cur}), 64'({1'b1, prev_d}));
            end
            if (out_valid_le && out_ready) begin
                check("byte_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("byte_le", 64'(cur[8:0]), 64'(e[8:0]));
                    check("byte_be", 64'(cur[17:9]), 64'(e[17:9]));
                end
            end
            prev_v  = out_valid_le;
            prev_hs = out_valid_le && out_ready;
            prev_d  = cur;
            if (in_valid && in_ready_le) begin
                last_in_hs = 1'b1;
                model_push(in_data, in_len, in_last);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] l, input logic la);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        in_last  = la;
        do begin
            tick();
            n++;
        end while (!last_in_hs && n < 200);
        check("push_accepted", 64'(last_in_hs), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({in_ready_le, out_valid_le, out_data_le, out_last_le, bc_le, dc_le}), 64'(0));
        check(tag, 64'({in_ready_be, out_valid_be, out_data_be, out_last_be, bc_be, dc_be}), 64'(0));
    endtask

    initial begin
        // Reset values and ready after the first edge following release.
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset_values");
        repeat (2) tick();
        reset_n = 1'b1;
        check("ready_before_edge", 64'(in_ready_le), 64'(0));
        tick();
        check("ready_after_reset", 64'(in_ready_le), 64'(1));
        check("idle_no_valid", 64'(out_valid_le), 64'(0));

        // Basic little-endian serialization with 2-cycle fill.
        push(32'h44332211, 3'd4, 1'b1);
        in_valid = 1'b0;
        check("t1_fill_gap", 64'(out_valid_le), 64'(0));
        tick();
        check("t1_first_byte", 64'({out_valid_le, out_last_le, out_data_le}), 64'({1'b1, 1'b0, 8'h11}));
        repeat (4) tick();
        check("t1_all_bytes", 64'(exp_q.size()), 64'(0));
        check("t1_byte_count", 64'(bc_le), 64'(16'd4));
        check("t1_idle_after", 64'(out_valid_le), 64'(0));

        // Partial word in both byte orders.
        push(32'hAABBCCDD, 3'd2, 1'b0);
        in_valid = 1'b0;
        tick();
        check("t2_le_first", 64'(out_data_le), 64'(8'hDD));
        check("t2_be_first", 64'(out_data_be), 64'(8'hAA));
        drain();
        tick();
        check("t2_idle_after", 64'(out_valid_le), 64'(0));

        // Back-to-back words: six bytes on six consecutive cycles.
        push(32'h04030201, 3'd4, 1'b0);
        push(32'h00000605, 3'd2, 1'b1);
        in_valid = 1'b0;
        check("t3_first_byte", 64'({out_valid_le, out_data_le}), 64'({1'b1, 8'h01}));
        repeat (6) tick();
        check("t3_no_bubble", 64'(exp_q.size()), 64'(0));
        check("t3_byte_count", 64'(bc_le), 64'(16'd12));

        // Backpressure: fill the FIFO, then release with random ready.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push({8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)}, 3'd4, 1'b0);
            if (k == 3) check("t4_ready_at_4", 64'(in_ready_le), 64'(1));
        end
        in_valid = 1'b0;
        check("t4_ready_full", 64'(in_ready_le), 64'(0));
        repeat (3) tick();
        check("t4_still_full", 64'(in_ready_le), 64'(0));
        check("t4_held_le", 64'({out_valid_le, out_data_le}), 64'({1'b1, 8'h00}));
        check("t4_held_be", 64'(out_data_be), 64'(8'h03));
        rand_rdy = 1'b1;
        push({8'd23, 8'd22, 8'd21, 8'd20}, 3'd4, 1'b1);
        in_valid = 1'b0;
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_byte_count", 64'(bc_le), 64'(16'd36));

        // Illegal lengths are accepted and dropped; drop counter saturates.
        push(32'h12345678, 3'd0, 1'b0);
        push(32'h9ABCDEF0, 3'd5, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_no_output", 64'(out_valid_le), 64'(0));
        end
        check("t5_drop_two", 64'(dc_le), 64'(8'd2));
        for (int k = 0; k < 300; k++) begin
            push(32'(k), 3'd7, 1'b0);
        end
        in_valid = 1'b0;
        tick();
        check("t5_drop_sat", 64'(dc_le), 64'(8'd255));
        check("t5_drop_sat_be", 64'(dc_be), 64'(8'd255));
        check("t5_bytes_kept", 64'(bc_le), 64'(16'd36));

        // Reset with byte 1 of a word pending.
        push(32'hDDCCBBAA, 3'd4, 1'b1);
        in_valid = 1'b0;
        tick();
        tick();
        check("t6_pending_b1", 64'({out_valid_le, out_data_le}), 64'({1'b1, 8'hBB}));
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset_outputs");
        exp_q.delete();
        prev_v  = 1'b0;
        prev_hs = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("t6_ready_back", 64'(in_ready_le), 64'(1));
        check("t6_no_residue", 64'(out_valid_le), 64'(0));
        push(32'h000000EE, 3'd1, 1'b1);
        in_valid = 1'b0;
        drain();
        repeat (3) tick();
        check("t6_idle_after", 64'(out_valid_le), 64'(0));
        check("t6_byte_count", 64'(bc_le), 64'(16'd1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_dword_serializer.md
# stream_dword_serializer

Upstream feeder for the byte-wide sample stream port. It accepts 32-bit words carrying 1–4 valid bytes over a valid/ready handshake and buffers them in a small word FIFO. It emits the valid bytes one per cycle on an 8-bit valid/ready stream that connects directly to the downstream byte consumer's `stream_in_valid`, `stream_in_data` and `stream_in_ready`. It also keeps byte and drop counters for test observation.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: word FIFO entries; power of two, ≥2.
- `BIG_ENDIAN`, default 0:
  - 0: byte 0 = `data[7:0]`; the valid bytes are the low `len` bytes.
  - 1: byte 0 = `data[31:24]`; the valid bytes are the high `len` bytes.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `stream_in_valid`  in  1  word valid.
- `stream_in_ready`  out  1  word accept (registered).
- `stream_in_data`  in  32  word payload.
- `stream_in_len`  in  3  valid byte count, legal values 1–4.
- `stream_in_last`  in  1  word ends a packet.
- `stream_out_valid`  out  1  byte valid.
- `stream_out_ready`  in  1  downstream accept.
- `stream_out_data`  out  8  byte payload.
- `stream_out_last`  out  1  final byte of a word that had `stream_in_last` set.
- `byte_count`  out  16  output byte handshakes; wraps.
- `drop_count`  out  8  illegal-length words dropped; saturates at 255.

## Operation

- **Input handshake** occurs when `stream_in_valid && stream_in_ready` at a rising edge.
  - Legal `len` (1–4): `{data, len, last}` is written to the FIFO.
  - `len` = 0 or 5–7: the word is accepted, not written, and `drop_count` increments (holds at 255).
- **`stream_in_ready`** is registered: it is 1 when the post-edge FIFO occupancy is < `FIFO_DEPTH`.
  - It does not depend on `stream_in_valid`.
  - A pop on the same edge does not free a slot for that edge's push decision. Simultaneous pop when full leaves ready low that cycle; it rises on the next edge.
- **Serializer FSM**, 2 states:
  - IDLE: `stream_out_valid` = 0. If the FIFO is non-empty, pop the head, load the shift register with `byte_idx` = 0, and go to SHIFT.
  - SHIFT: present byte `byte_idx` of the held word.
    - On an output handshake with `byte_idx` < `len`−1: increment `byte_idx`.
    - On an output handshake with `byte_idx` = `len`−1 and the FIFO non-empty: pop the next word on the same edge and stay in SHIFT (no bubble).
    - On an output handshake with `byte_idx` = `len`−1 and the FIFO empty: go to IDLE.
- **`stream_out_last`** = held `last` && (`byte_idx` == `len`−1).
- **Output stability:** once `stream_out_valid` rises, `stream_out_data` and `stream_out_last` are held stable until a handshake. Valid never drops without a handshake, except on reset.
- **`byte_count`** increments on every output handshake and wraps from 0xFFFF to 0.
- **FIFO** uses `log2(FIFO_DEPTH)`-bit pointers that wrap, plus an occupancy counter.

## Timing

- **Reset values**, applied asynchronously while `reset_n` = 0: all outputs are 0 (`stream_in_ready`, `stream_out_valid`, `stream_out_data`, `stream_out_last`, `byte_count`, `drop_count`).
- **After reset release:** `stream_in_ready` = 1 after the first rising edge.
- **Latency:** a word accepted at edge N with the serializer in IDLE presents byte 0 after edge N+1, a 2-cycle fill.
- **Throughput:** with `stream_out_ready` held high, one byte per cycle, including across word boundaries.
- **Reset mid-operation:** the FIFO is flushed, the partially sent word is discarded, the FSM returns to IDLE, and both counters clear. No residual bytes appear after release.
- **Edge cases:**
  - Input stalled while the FIFO is empty: output stays idle with no spurious valid.
  - Output stalled: the FIFO fills, and ready drops on the edge that makes it full.

## Test plan

1. **Basic serialization, little-endian.** Reset, then push 0x44332211 with `len`=4, `last`=1, ready high. Required: bytes 11,22,33,44 on consecutive cycles starting 2 cycles after accept; `last` only on 44; `byte_count`=4.
2. **Partial word, both endiannesses.** `BIG_ENDIAN`=0: push 0xAABBCCDD, `len`=2, `last`=0 → output DD,CC, `last`=0. `BIG_ENDIAN`=1: same word → output AA,BB.
3. **Back-to-back words, no bubble.** Push 0x04030201 (`len`=4) and 0x00000605 (`len`=2, `last`=1) in consecutive cycles. Required: 01..06 on 6 consecutive cycles; `last` on 06 only.
4. **Backpressure and full.**
   - With `FIFO_DEPTH`=4 and `stream_out_ready`=0, push 6 words. Required: `stream_in_ready` drops after the 5th accept (4 queued plus 1 held in the serializer); byte 0 of the first word is held stable.
   - Then random `stream_out_ready`. Required: all 24 bytes arrive in order with none lost or duplicated.
5. **Illegal length.**
   - Push words with `len`=0 and `len`=5. Required: both accepted, no output bytes, `drop_count`=2.
   - Push 300 illegal words. Required: `drop_count`=255.
6. **Reset mid-word.**
   - With byte 1 of a 4-byte word pending, assert `reset_n`=0 between edges. Required: `stream_out_valid` falls immediately and all outputs are 0.
   - After release, push 0x000000EE with `len`=1. Required: only EE appears; `byte_count`=1.
